brick_collider: RTL

Collision resolver for the brick-breaker datapath; it produces the `cX`/`cY` collision flags that the ball block consumes. On each `go` strobe it latches the ball position and velocity, predicts the next position, and checks walls, floor, paddle and a 10×4 brick map. It clears any bricks that were struck and returns the reflect flags with a one-cycle `done` pulse. It owns the authoritative brick map and brick count used by the renderer and the game FSM.

---
 rtl/brick_collider.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/brick_collider.sv
// Collision resolver for the brick-breaker datapath: predicts the next ball position and
// resolves wall, floor, paddle and brick-map collisions. Optional score counter: BRICK_SCORE_EN.
module brick_collider #(
    parameter int XMAX       = 159,
    parameter int YMAX       = 119,
    parameter int BRICK_Y0   = 16,
    parameter int BRICK_ROWS = 4,
    parameter int PADDLE_Y   = 110,
    parameter int PADDLE_W   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        load,
    input  logic [7:0]  ballX,
    input  logic [7:0]  ballY,
    input  logic [2:0]  vX,
    input  logic [2:0]  vY,
    input  logic [7:0]  paddleX,
    output logic        busy,
    output logic        done,
    output logic        cX,
    output logic        cY,
    output logic        miss,
    output logic [39:0] brick_map,
    output logic [5:0]  bricks_left,
    output logic        all_clear,
    output logic [7:0]  score
);

    localparam int                 NBRICK     = 10 * BRICK_ROWS;
    localparam logic [39:0]        FULL_MAP   = {40{1'b1}} >> (40 - NBRICK);
    localparam logic [5:0]         FULL_COUNT = 6'(NBRICK);
    // Positions are kept 10-bit signed so ballX up to 255 plus velocity never wraps.
    localparam logic signed [9:0]  XMAX_S     = 10'(XMAX);
    localparam logic signed [9:0]  YMAX_S     = 10'(YMAX);
    localparam logic signed [9:0]  BY0_S      = 10'(BRICK_Y0);
    localparam logic signed [9:0]  BH_S       = 10'(8 * BRICK_ROWS);
    localparam logic signed [9:0]  PADY_S     = 10'(PADDLE_Y);
    localparam logic signed [9:0]  PADWM1_S   = 10'(PADDLE_W - 1);

    typedef enum logic [2:0] {IDLE, PRED, CHK_H, CHK_V, CHK_D, RESP} state_t;

    state_t             state;
    logic [7:0]         bx, by, px;
    logic [2:0]         vx, vy;
    logic signed [9:0]  nX, nY;
    logic               accX, accY, accMiss, hHit, vHit;

    logic signed [9:0]  predX, predY, pxS, probeX, probeY;
    logic               padHit, probeEn, hit;
    logic [6:0]         probeRes;

    function automatic logic [6:0] probe(input logic signed [9:0] x, input logic signed [9:0] y);
        logic signed [9:0] dy;
        logic              ok;
        logic [5:0]        idx;
        dy  = y - BY0_S;
        ok  = (x >= 10'sd0) && (x <= XMAX_S) && (x[7:4] < 4'd10) && (dy >= 10'sd0) && (dy < BH_S);
        idx = 6'(dy[6:3]) * 6'd10 + 6'(x[7:4]);
        return {ok, idx};
    endfunction

    always_comb begin
        predX  = $signed({2'b00, bx}) + $signed({{7{vx[2]}}, vx});
        predY  = $signed({2'b00, by}) + $signed({{7{vy[2]}}, vy});
        pxS    = $signed({2'b00, px});
        padHit = ($signed(vy) > 3'sd0) && (predY == PADY_S) && (predX >= pxS) && (predX <= pxS + PADWM1_S);
        probeX = nX;
        probeY = nY;
        if (state == CHK_H) probeY = $signed({2'b00, by});
        if (state == CHK_V) probeX = $signed({2'b00, bx});
        probeRes = probe(probeX, probeY);
        // The diagonal probe only counts when neither axis probe found a brick.
        probeEn  = (state == CHK_H) || (state == CHK_V) || ((state == CHK_D) && !hHit && !vHit);
        hit      = probeEn && probeRes[6] && brick_map[probeRes[5:0]];
    end

    assign all_clear = (bricks_left == 6'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bx          <= 8'd0;
            by          <= 8'd0;
            px          <= 8'd0;
            vx          <= 3'd0;
            vy          <= 3'd0;
            nX          <= 10'sd0;
            nY          <= 10'sd0;
            accX        <= 1'b0;
            accY        <= 1'b0;
            accMiss     <= 1'b0;
            hHit        <= 1'b0;
            vHit        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cX          <= 1'b0;
            cY          <= 1'b0;
            miss        <= 1'b0;
            brick_map   <= FULL_MAP;
            bricks_left <= FULL_COUNT;
        end else if (load) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cX          <= 1'b0;
            cY          <= 1'b0;
            miss        <= 1'b0;
            brick_map   <= FULL_MAP;
            bricks_left <= FULL_COUNT;
        end else begin
            busy <= (state != IDLE);
            done <= (state == RESP);
            cX   <= (state == RESP) && accX;
            cY   <= (state == RESP) && accY && !accMiss;
            miss <= (state == RESP) && accMiss;
            if (hit) begin
                brick_map[probeRes[5:0]] <= 1'b0;
                bricks_left              <= bricks_left - 6'd1;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        bx    <= ballX;
                        by    <= ballY;
                        vx    <= vX;
                        vy    <= vY;
                        px    <= paddleX;
                        state <= PRED;
                    end
                end
                PRED: begin
                    nX      <= predX;
                    nY      <= predY;
                    accX    <= (predX < 10'sd0) || (predX > XMAX_S);
                    accY    <= (predY < 10'sd0) || padHit;
                    accMiss <= (predY > YMAX_S);
                    hHit    <= 1'b0;
                    vHit    <= 1'b0;
                    state   <= CHK_H;
                end
                CHK_H: begin
                    if (hit) begin
                        accX <= 1'b1;
                        hHit <= 1'b1;
                    end
                    state <= CHK_V;
                end
                CHK_V: begin
                    if (hit) begin
                        accY <= 1'b1;
                        vHit <= 1'b1;
                    end
                    state <= CHK_D;
                end
                CHK_D: begin
                    if (hit) begin
                        accX <= 1'b1;
                        accY <= 1'b1;
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRICK_SCORE_EN
    // Bricks clear one per cycle, so a double hit naturally adds two over two cycles.
    always_ff @(posedge clock) begin
        if (reset)
            score <= 8'd0;
        else if (!load && hit && (score != 8'hFF))
            score <= score + 8'd1;
    end
`else
    assign score = 8'd0;
`endif

endmodule
